ncl_count_receiver32: RTL and testbench
=======================================

NCL_COUNT_RECEIVER32 -- requirements
Module: ncl_count_receiver32

Interface
REQ-001 Parameter WIDTH, default 32: number of dual-rail sum digits received.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per rail, legal values 2..3.
REQ-003 clk  in  1  sole clock; every flop is in this domain.
REQ-004 init_n  in  1  asynchronous, active-low reset.
REQ-005 sum_t  in  WIDTH  rail-1 of each sum digit, asynchronous to clk.
REQ-006 sum_f  in  WIDTH  rail-0 of each sum digit, asynchronous to clk.
REQ-007 carry_t, carry_f  in  1 each  dual-rail carry-out digit, asynchronous to clk.
REQ-008 sum_comp  out  WIDTH  per-digit completion acknowledge to the producer: 1 = DATA accepted, request NULL; 0 = request DATA.
REQ-009 carry_comp  out  1  completion acknowledge for the carry digit.
REQ-010 word_valid  out  1  a complete captured word is presented.
REQ-011 word_ready  in  1  consumer accepts the word.
REQ-012 count  out  WIDTH  captured single-rail count value.
REQ-013 wrap  out  1  captured carry-out value.
REQ-014 rail_err  out  1  sticky illegal-code flag.
REQ-015 seq_err  out  1  sticky sequence-mismatch flag.

Function
REQ-016 Each of the WIDTH+1 digits (sum plus carry) is processed independently; digit decode: NULL = 00, DATA0 = f=1, DATA1 = t=1, ILLEGAL = 11.
REQ-017 Each rail passes through SYNC_STAGES flops before any decision; decisions use synchronized values only.
REQ-018 Per-digit state is {ack, captured}; reset state {0,0}.
REQ-019 Capture: when a digit is DATA and ack=0 and captured=0, the digit value is stored, captured=1 and ack=1 on the same edge.
REQ-020 Release: when a digit is NULL and ack=1, ack returns to 0; captured is unaffected.
REQ-021 A DATA digit arriving while captured=1 is not sampled; ack stays 0 and the producer stalls until the word transfers.
REQ-022 Latency: with SYNC_STAGES=2, ack rises on the 3rd rising clk edge after the rails settle to DATA, and falls on the 3rd edge after they settle to NULL.
REQ-023 word_valid is the AND of all WIDTH+1 captured flags, with no additional register stage.
REQ-024 count and wrap hold the stored digit values and are stable while word_valid=1.
REQ-025 Transfer occurs on an edge where word_valid=1 and word_ready=1; on that edge every captured flag clears, and ack flags are unaffected.
REQ-026 When a digit's DATA is pending on the transfer edge itself, that digit captures on the following edge at the earliest.
REQ-027 rail_err sets when any synchronized digit is ILLEGAL for 2 consecutive cycles; it clears only on reset, and ILLEGAL is never captured.
REQ-028 Sequence check: from the second transferred word onward, seq_err sets on a transfer whose {wrap,count} differs from {prev==all-ones, prev+1 mod 2^WIDTH}; it clears only on reset.
REQ-029 The first transfer after reset only loads prev.

Reset
REQ-030 init_n low asynchronously forces sum_comp=0, carry_comp=0, word_valid=0, count=0, wrap=0, rail_err=0, seq_err=0, prev-valid=0, and clears every synchronizer.
REQ-031 Reset deassertion is synchronized to clk internally; the first capture occurs no earlier than SYNC_STAGES+1 edges after release.
REQ-032 Reset in mid-operation discards any partial word; after release the block waits for NULL-or-DATA per REQ-019 and REQ-020.

Structure
REQ-033 Shared package ncl_rx_pkg holds the digit-code constants (NULL, DATA0, DATA1, ILLEGAL) and the default WIDTH.
REQ-034 Sub-module ncl_digit_rx contains one digit's synchronizer, capture register and ack logic, and is instantiated WIDTH+1 times.
REQ-035 The top level holds the word handshake, prev register and error flags.

Verification
REQ-036 Reset, then all digits NULL -> all comps=0, word_valid=0, count=0.
REQ-037 All digits present 0x00000005 with carry DATA0 simultaneously -> every comp=1 on the 3rd edge, word_valid=1 the same edge, count=0x00000005, wrap=0; NULL returned -> comps=0 3 edges later.
REQ-038 Digits skewed by 0..20 cycles with word_ready=0 for 50 cycles and next wavefront 0x00000006 pending -> count stays 0x00000005, the new DATA digits' comps stay 0; word_ready=1 -> 0x00000006 captured, seq_err=0.
REQ-039 Words 0xFFFFFFFF/carry0 then 0x00000000/carry1 -> wrap=1 on the second word, seq_err=0; then 0x00000005 followed by 0x00000007 -> seq_err=1 and it remains 1.
REQ-040 Digit 7 driven 11 for 3 cycles -> rail_err=1, digit 7 not captured; 11 for 1 cycle only -> rail_err=0.
REQ-041 init_n pulsed low with 16 digits captured -> all outputs reach their reset values immediately, and the next full word is captured correctly with no seq_err.

Source files
------------

// File: rtl/ncl_rx_pkg.sv
// Shared definitions for the NCL count receiver: dual-rail digit codes and the default word width.
package ncl_rx_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Dual-rail digit encoding, packed as {rail_t, rail_f}
    typedef enum logic [1:0] {
        CODE_NULL    = 2'b00,
        CODE_DATA0   = 2'b01,
        CODE_DATA1   = 2'b10,
        CODE_ILLEGAL = 2'b11
    } digit_code_e;

    function automatic digit_code_e decode_digit(input logic rail_t, input logic rail_f);
        return digit_code_e'({rail_t, rail_f});
    endfunction

endpackage

// File: rtl/ncl_digit_rx.sv
// One dual-rail digit receiver: rail synchronizers, capture register, completion ack
// and a two-cycle illegal-code detector.
module ncl_digit_rx
    import ncl_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic rail_t,
    input  logic rail_f,
    input  logic clear,
    output logic ack,
    output logic captured,
    output logic value,
    output logic illegal
);

    logic [SYNC_STAGES-1:0] sync_t_q, sync_t_d;
    logic [SYNC_STAGES-1:0] sync_f_q, sync_f_d;
    logic                   ack_q, ack_d;
    logic                   cap_q, cap_d;
    logic                   val_q, val_d;
    logic                   illegal_seen_q, illegal_seen_d;

    digit_code_e code;
    logic        is_data;
    logic        is_null;
    logic        is_illegal;

    // Decisions are made only on the last synchronizer stage of each rail
    assign code       = decode_digit(sync_t_q[SYNC_STAGES-1], sync_f_q[SYNC_STAGES-1]);
    assign is_data    = (code == CODE_DATA0) || (code == CODE_DATA1);
    assign is_null    = (code == CODE_NULL);
    assign is_illegal = (code == CODE_ILLEGAL);

    // Shift each asynchronous rail into its synchronizer chain
    always_comb begin
        sync_t_d = {sync_t_q[SYNC_STAGES-2:0], rail_t};
        sync_f_d = {sync_f_q[SYNC_STAGES-2:0], rail_f};
    end

    // Capture DATA only into an empty, un-acked slot; drop ack once NULL returns; a word
    // transfer empties the slot but leaves the ack alone
    always_comb begin
        ack_d          = ack_q;
        cap_d          = cap_q;
        val_d          = val_q;
        illegal_seen_d = is_illegal;
        if (clear) begin
            cap_d = 1'b0;
        end
        if (is_data && !ack_q && !cap_q) begin
            cap_d = 1'b1;
            ack_d = 1'b1;
            val_d = (code == CODE_DATA1);
        end else if (is_null && ack_q) begin
            ack_d = 1'b0;
        end
    end

    // State register for synchronizers, handshake and capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_t_q       <= '0;
            sync_f_q       <= '0;
            ack_q          <= 1'b0;
            cap_q          <= 1'b0;
            val_q          <= 1'b0;
            illegal_seen_q <= 1'b0;
        end else begin
            sync_t_q       <= sync_t_d;
            sync_f_q       <= sync_f_d;
            ack_q          <= ack_d;
            cap_q          <= cap_d;
            val_q          <= val_d;
            illegal_seen_q <= illegal_seen_d;
        end
    end

    assign ack      = ack_q;
    assign captured = cap_q;
    assign value    = val_q;
    assign illegal  = is_illegal && illegal_seen_q;

endmodule

// File: rtl/ncl_count_receiver32.sv
// NCL dual-rail count receiver: WIDTH sum digits plus a carry digit are captured
// independently and presented as one single-rail word with sequence and rail checks.
module ncl_count_receiver32
    import ncl_rx_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
)
(
    input  logic             clk,
    input  logic             init_n,
    input  logic [WIDTH-1:0] sum_t,
    input  logic [WIDTH-1:0] sum_f,
    input  logic             carry_t,
    input  logic             carry_f,
    output logic [WIDTH-1:0] sum_comp,
    output logic             carry_comp,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             rail_err,
    output logic             seq_err
);

    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic                   rst_int_n;

    logic [WIDTH:0] rails_t;
    logic [WIDTH:0] rails_f;
    logic [WIDTH:0] ack_all;
    logic [WIDTH:0] cap_all;
    logic [WIDTH:0] val_all;
    logic [WIDTH:0] illegal_all;
    logic           transfer;

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             seq_err_q, seq_err_d;
    logic             rail_err_q, rail_err_d;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    // Reset asserts immediately but is released only after SYNC_STAGES clean clock edges
    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Reset release synchronizer
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[SYNC_STAGES-1];

    // Carry digit sits above the sum digits
    assign rails_t = {carry_t, sum_t};
    assign rails_f = {carry_f, sum_f};

    genvar i;
    for (i = 0; i <= WIDTH; i++) begin : g_digit
        ncl_digit_rx #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_digit (
            .clk     (clk),
            .rst_n   (rst_int_n),
            .rail_t  (rails_t[i]),
            .rail_f  (rails_f[i]),
            .clear   (transfer),
            .ack     (ack_all[i]),
            .captured(cap_all[i]),
            .value   (val_all[i]),
            .illegal (illegal_all[i])
        );
    end

    assign word_valid = &cap_all;
    assign transfer   = word_valid && word_ready;
    assign sum_comp   = ack_all[WIDTH-1:0];
    assign carry_comp = ack_all[WIDTH];
    assign count      = val_all[WIDTH-1:0];
    assign wrap       = val_all[WIDTH];

    // Value the next word must carry if the producer counts correctly
    assign next_count = prev_q + WIDTH'(1);
    assign next_wrap  = &prev_q;

    // Sticky error flags and previous-word tracking, updated on each word transfer
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        seq_err_d    = seq_err_q;
        rail_err_d   = rail_err_q;
        if (|illegal_all) begin
            rail_err_d = 1'b1;
        end
        if (transfer) begin
            prev_d       = count;
            prev_valid_d = 1'b1;
            if (prev_valid_q && ({wrap, count} != {next_wrap, next_count})) begin
                seq_err_d = 1'b1;
            end
        end
    end

    // Word-level state register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
            rail_err_q   <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            seq_err_q    <= seq_err_d;
            rail_err_q   <= rail_err_d;
        end
    end

    assign rail_err = rail_err_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_ncl_count_receiver32.sv
// Self-checking bench for ncl_count_receiver32: scoreboard of transferred words,
// a vector table for the sequence checker, and hand-written latency/skew/error/reset sequences.
module tb_ncl_count_receiver32;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             init_n = 1'b0;
    logic [WIDTH-1:0] sum_t = '0;
    logic [WIDTH-1:0] sum_f = '0;
    logic             carry_t = 1'b0;
    logic             carry_f = 1'b0;
    logic [WIDTH-1:0] sum_comp;
    logic             carry_comp;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             rail_err;
    logic             seq_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] sb_exp;
    logic [WIDTH:0] data_en;

    typedef struct {
        logic [WIDTH-1:0] value;
        logic             carry;
        logic             exp_seq_err;
    } vec_t;

    vec_t vecs[9];

    ncl_count_receiver32 #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .init_n    (init_n),
        .sum_t     (sum_t),
        .sum_f     (sum_f),
        .carry_t   (carry_t),
        .carry_f   (carry_f),
        .sum_comp  (sum_comp),
        .carry_comp(carry_comp),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .count     (count),
        .wrap      (wrap),
        .rail_err  (rail_err),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // All stimulus changes happen 3 time units after a rising edge
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] st, input logic [WIDTH-1:0] sf,
                                 input logic ct, input logic cf);
        sum_t   = st;
        sum_f   = sf;
        carry_t = ct;
        carry_f = cf;
    endtask

    task automatic driveWord(input logic [WIDTH-1:0] value, input logic carry);
        applyStimulus(value, ~value, carry, ~carry);
    endtask

    task automatic driveNull();
        applyStimulus('0, '0, 1'b0, 1'b0);
    endtask

    task automatic waitComps(input string name, input logic [WIDTH-1:0] es, input logic ec);
        int k = 0;
        while (k < 300 && !(sum_comp === es && carry_comp === ec)) begin
            tick();
            k++;
        end
        checkOutput(name, 64'({carry_comp, sum_comp}), 64'({ec, es}));
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] value, input logic carry);
        exp_q.push_back({carry, value});
        driveWord(value, carry);
        waitComps("ack word", '1, 1'b1);
        driveNull();
        waitComps("release word", '0, 1'b0);
    endtask

    task automatic doReset();
        init_n = 1'b0;
        repeat (3) tick();
        init_n = 1'b1;
        repeat (6) tick();
    endtask

    // Scoreboard: a transfer happens on the rising edge following a valid&ready sample
    always @(negedge clk) begin
        if (init_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL scoreboard unexpected word: got 0x%0h, expected none", {wrap, count});
            end else begin
                sb_exp = exp_q.pop_front();
                checkOutput("scoreboard word", 64'({wrap, count}), 64'(sb_exp));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0001, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_0002, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0003, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0004, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0005, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0007, 1'b0, 1'b1};
        vecs[8] = '{32'h0000_0008, 1'b0, 1'b1};

        repeat (3) tick();
        init_n = 1'b1;
        repeat (6) tick();

        // Idle after reset with all digits NULL
        checkOutput("reset sum_comp", 64'(sum_comp), 64'(0));
        checkOutput("reset carry_comp", 64'(carry_comp), 64'(0));
        checkOutput("reset word_valid", 64'(word_valid), 64'(0));
        checkOutput("reset count", 64'(count), 64'(0));
        checkOutput("reset wrap", 64'(wrap), 64'(0));
        checkOutput("reset rail_err", 64'(rail_err), 64'(0));
        checkOutput("reset seq_err", 64'(seq_err), 64'(0));

        // Simultaneous wavefront 0x5: ack and word_valid on the 3rd edge
        exp_q.push_back({1'b0, 32'h5});
        driveWord(32'h5, 1'b0);
        tick();
        tick();
        checkOutput("ack not before 3rd edge", 64'({carry_comp, sum_comp}), 64'(0));
        tick();
        checkOutput("ack on 3rd edge", 64'({carry_comp, sum_comp}), 64'h1_FFFF_FFFF);
        checkOutput("word_valid on 3rd edge", 64'(word_valid), 64'(1));
        checkOutput("count 0x5", 64'(count), 64'h5);
        checkOutput("wrap 0", 64'(wrap), 64'(0));
        driveNull();
        tick();
        tick();
        checkOutput("ack held 2 edges after NULL", 64'({carry_comp, sum_comp}), 64'h1_FFFF_FFFF);
        tick();
        checkOutput("ack drops 3rd edge after NULL", 64'({carry_comp, sum_comp}), 64'(0));
        checkOutput("word still valid", 64'(word_valid), 64'(1));

        // Skewed wavefront 0x6 while consumer stalls
        exp_q.push_back({1'b0, 32'h6});
        data_en = '0;
        for (int c = 0; c < 50; c++) begin
            for (int i = 0; i <= WIDTH; i++) begin
                if (((i * 7) % 21) <= c) data_en[i] = 1'b1;
            end
            applyStimulus(data_en[WIDTH-1:0] & 32'h6, data_en[WIDTH-1:0] & ~32'h6, 1'b0, data_en[WIDTH]);
            tick();
            if (c == 25) checkOutput("count held mid-stall", 64'(count), 64'h5);
        end
        checkOutput("count held after stall", 64'(count), 64'h5);
        checkOutput("new digits not acked", 64'({carry_comp, sum_comp}), 64'(0));
        checkOutput("word_valid during stall", 64'(word_valid), 64'(1));
        word_ready = 1'b1;
        waitComps("ack 0x6 after release", '1, 1'b1);
        driveNull();
        waitComps("release 0x6", '0, 1'b0);
        checkOutput("count 0x6", 64'(count), 64'h6);
        checkOutput("seq_err after 5->6", 64'(seq_err), 64'(0));

        // Sequence checker table, starting fresh
        doReset();
        for (int v = 0; v < 9; v++) begin
            sendWord(vecs[v].value, vecs[v].carry);
            checkOutput("seq_err row", 64'(seq_err), 64'(vecs[v].exp_seq_err));
        end

        // Digit 7 illegal for one cycle, then for three
        sum_t[7] = 1'b1;
        sum_f[7] = 1'b1;
        tick();
        sum_t[7] = 1'b0;
        sum_f[7] = 1'b0;
        repeat (5) tick();
        checkOutput("rail_err single-cycle illegal", 64'(rail_err), 64'(0));
        sum_t[7] = 1'b1;
        sum_f[7] = 1'b1;
        repeat (3) tick();
        sum_t[7] = 1'b0;
        sum_f[7] = 1'b0;
        repeat (4) tick();
        checkOutput("rail_err 3-cycle illegal", 64'(rail_err), 64'(1));
        checkOutput("digit 7 not acked", 64'(sum_comp[7]), 64'(0));
        checkOutput("no word from illegal", 64'(word_valid), 64'(0));

        // Partial word, then asynchronous reset in mid-operation
        word_ready = 1'b0;
        applyStimulus(32'h0000_ABCD, 32'h0000_5432, 1'b0, 1'b0);
        repeat (6) tick();
        checkOutput("16 digits acked", 64'({carry_comp, sum_comp}), 64'h0_0000_FFFF);
        #1 init_n = 1'b0;
        #1;
        checkOutput("async reset sum_comp", 64'(sum_comp), 64'(0));
        checkOutput("async reset word_valid", 64'(word_valid), 64'(0));
        checkOutput("async reset count", 64'(count), 64'(0));
        checkOutput("async reset rail_err", 64'(rail_err), 64'(0));
        checkOutput("async reset seq_err", 64'(seq_err), 64'(0));
        driveNull();
        repeat (3) tick();
        init_n = 1'b1;
        repeat (6) tick();
        word_ready = 1'b1;
        sendWord(32'h1234_5678, 1'b0);
        sendWord(32'h1234_5679, 1'b0);
        checkOutput("seq_err after reset", 64'(seq_err), 64'(0));
        repeat (3) tick();
        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
